zx_screen_reader: RTL

ZX_SCREEN_READER -- requirements
Module: zx_screen_reader

---
 rtl/zx_video_pkg.sv | 43 ++++
 rtl/zx_video_timing.sv | 77 +++++++
 rtl/zx_screen_reader.sv | 104 ++++++++++
 3 files changed

// File: rtl/zx_video_pkg.sv
// Shared timing constants, cell-phase encoding and screen address helpers for the ZX video reader.
// Pure declarations; no clocked logic lives here.
package zx_video_pkg;

    localparam logic [8:0] H_TOTAL      = 9'd448;
    localparam logic [8:0] V_TOTAL      = 9'd312;
    localparam logic [8:0] H_LAST       = H_TOTAL - 9'd1;
    localparam logic [8:0] V_LAST       = V_TOTAL - 9'd1;
    localparam logic [8:0] H_ACT        = 9'd256;
    localparam logic [8:0] V_ACT        = 9'd192;
    localparam logic [8:0] V_ACT_LAST   = V_ACT - 9'd1;
    localparam logic [8:0] H_SYNC_START = 9'd320;
    localparam logic [8:0] H_SYNC_END   = 9'd351;
    localparam logic [8:0] V_SYNC_START = 9'd248;
    localparam logic [8:0] V_SYNC_END   = 9'd251;
    localparam logic [8:0] H_BLANK      = 9'd384;
    localparam logic [8:0] V_BLANK      = 9'd280;
    localparam logic [8:0] INT_LEN      = 9'd32;
    localparam logic [8:0] H_FETCH_PRE  = 9'd440;
    localparam logic [8:0] H_FETCH_END  = 9'd247;
    localparam logic [15:0] ATTR_BASE   = 16'h1800;
    localparam int          FLASH_BIT   = 4;

    typedef enum logic [2:0] {
        PH_BM_ADDR = 3'd0,
        PH_BM_CAP  = 3'd1,
        PH_AT_ADDR = 3'd2,
        PH_AT_CAP  = 3'd3,
        PH_IDLE4   = 3'd4,
        PH_IDLE5   = 3'd5,
        PH_IDLE6   = 3'd6,
        PH_LOAD    = 3'd7
    } phase_t;

    function automatic logic [15:0] bm_addr(input logic [7:0] y, input logic [4:0] c);
        return {3'b000, y[7:6], y[2:0], y[5:3], c};
    endfunction

    function automatic logic [15:0] at_addr(input logic [4:0] row, input logic [4:0] c);
        return ATTR_BASE + {6'b000000, row, c};
    endfunction

endpackage

// File: rtl/zx_video_timing.sv
// Raster counters, frame counter and sync/blank/interrupt decode; decodes registered one pix_ce late.
// No backpressure: pix_ce low freezes every register.
module zx_video_timing
    import zx_video_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_pix_ce,
    output logic [8:0] o_hcnt,
    output logic [8:0] o_vcnt,
    output logic       o_flash,
    output logic       o_active,
    output logic       o_dark,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_blank,
    output logic       o_int_n
);

    logic [8:0] r_hcnt;
    logic [8:0] r_vcnt;
    logic [4:0] r_frame;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_blank;
    logic       r_int_n;

    logic w_hwrap;
    logic w_vwrap;
    logic w_hsync;
    logic w_vsync;
    logic w_blank;
    logic w_int;

    assign w_hwrap = (r_hcnt == H_LAST);
    assign w_vwrap = (r_vcnt == V_LAST);
    assign w_hsync = (r_hcnt >= H_SYNC_START) && (r_hcnt <= H_SYNC_END);
    assign w_vsync = (r_vcnt >= V_SYNC_START) && (r_vcnt <= V_SYNC_END);
    assign w_blank = (r_hcnt >= H_BLANK) || (r_vcnt >= V_BLANK);
    assign w_int   = (r_vcnt == V_SYNC_START) && (r_hcnt < INT_LEN);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_frame <= '0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
            r_blank <= 1'b0;
            r_int_n <= 1'b1;
        end else if (i_pix_ce) begin
            r_hcnt <= w_hwrap ? 9'd0 : r_hcnt + 9'd1;
            if (w_hwrap) begin
                r_vcnt <= w_vwrap ? 9'd0 : r_vcnt + 9'd1;
                if (w_vwrap) begin
                    r_frame <= r_frame + 5'd1;
                end
            end
            r_hsync <= w_hsync;
            r_vsync <= w_vsync;
            r_blank <= w_blank;
            r_int_n <= !w_int;
        end
    end

    assign o_hcnt   = r_hcnt;
    assign o_vcnt   = r_vcnt;
    assign o_flash  = r_frame[FLASH_BIT];
    assign o_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    // Sync periods are not part of the visible border, so they go dark with blank.
    assign o_dark   = w_blank || w_hsync || w_vsync;
    assign o_hsync  = r_hsync;
    assign o_vsync  = r_vsync;
    assign o_blank  = r_blank;
    assign o_int_n  = r_int_n;

endmodule

// File: rtl/zx_screen_reader.sv
// ZX Spectrum screen fetch/shift pipeline: reads bitmap+attribute one cell ahead, emits 4-bit colour.
// Colour and syncs lag the raster by one pix_ce; pix_ce low stalls everything (no other backpressure).
module zx_screen_reader
    import zx_video_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        pix_ce,
    input  logic [2:0]  border,
    output logic [15:0] addr_b,
    input  logic [7:0]  dout_b,
    output logic [3:0]  color,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        int_n
);

    logic [8:0] w_hcnt;
    logic [8:0] w_vcnt;
    logic       w_flash;
    logic       w_active;
    logic       w_dark;

    zx_video_timing u_timing (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_pix_ce (pix_ce),
        .o_hcnt   (w_hcnt),
        .o_vcnt   (w_vcnt),
        .o_flash  (w_flash),
        .o_active (w_active),
        .o_dark   (w_dark),
        .o_hsync  (hsync),
        .o_vsync  (vsync),
        .o_blank  (blank),
        .o_int_n  (int_n)
    );

    logic [15:0] r_addr;
    logic [7:0]  r_bm;
    logic [7:0]  r_at;
    logic [7:0]  r_shift;
    logic [7:0]  r_attr;
    logic [3:0]  r_color;

    logic        w_pre;
    logic        w_fetch;
    logic [7:0]  w_fy;
    logic [4:0]  w_cell;
    phase_t      w_phase;
    logic        w_pix;
    logic [3:0]  w_color;

    // The last 8 pixels of a line prefetch cell 0 of the next line (line 311 wraps to 0).
    assign w_pre   = (w_hcnt >= H_FETCH_PRE);
    assign w_fetch = w_pre ? ((w_vcnt == V_LAST) || (w_vcnt < V_ACT_LAST))
                           : ((w_hcnt <= H_FETCH_END) && (w_vcnt < V_ACT));
    assign w_fy    = w_pre ? ((w_vcnt == V_LAST) ? 8'd0 : w_vcnt[7:0] + 8'd1) : w_vcnt[7:0];
    assign w_cell  = w_pre ? 5'd0 : w_hcnt[7:3] + 5'd1;
    assign w_phase = phase_t'(w_hcnt[2:0]);
    assign w_pix   = r_shift[7] ^ (r_attr[7] & w_flash);

    always_comb begin
        w_color = 4'h0;
        if (w_active) begin
            w_color = {r_attr[6], w_pix ? r_attr[2:0] : r_attr[5:3]};
        end else if (!w_dark) begin
            w_color = {1'b0, border};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= '0;
            r_bm    <= '0;
            r_at    <= '0;
            r_shift <= '0;
            r_attr  <= '0;
            r_color <= '0;
        end else if (pix_ce) begin
            if (w_fetch) begin
                case (w_phase)
                    PH_BM_ADDR: r_addr <= bm_addr(w_fy, w_cell);
                    PH_BM_CAP:  r_bm   <= dout_b;
                    PH_AT_ADDR: r_addr <= at_addr(w_fy[7:3], w_cell);
                    PH_AT_CAP:  r_at   <= dout_b;
                    default: ;
                endcase
            end
            if (w_fetch && (w_phase == PH_LOAD)) begin
                r_shift <= r_bm;
                r_attr  <= r_at;
            end else if (w_active) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end
            r_color <= w_color;
        end
    end

    assign addr_b = r_addr;
    assign color  = r_color;

endmodule
